// File: rtl/bp_pkg.sv
// Shared definitions for the binary belief-propagation fabric.
// Holds the message width default, collector FSM encoding and the uniform-belief constant.
package bp_pkg;

  localparam int BP_MSG_W = 8;
  localparam int BP_SHIFT_W = 3;

  // 0.5 in Q0.8; unary blocks drive this when they carry no information
  localparam logic [BP_MSG_W-1:0] BP_UNIFORM_BELIEF = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_MUL     = 3'd2,
    ST_NORM    = 3'd3,
    ST_DONE    = 3'd4
  } bc_state_t;

endpackage

// File: rtl/belief_normalizer.sv
// Single normalisation step for a 2-state belief: left-shift by one,
// plus detection of "already normalised" (either MSB set) and 0/0 collapse.
module belief_normalizer #(
  parameter int MSG_W = 8
) (
  input  logic [MSG_W-1:0] i_acc0,
  input  logic [MSG_W-1:0] i_acc1,
  output logic [MSG_W-1:0] o_shl0,
  output logic [MSG_W-1:0] o_shl1,
  output logic             o_both_zero,
  output logic             o_msb_set
);

  assign o_shl0      = {i_acc0[MSG_W-2:0], 1'b0};
  assign o_shl1      = {i_acc1[MSG_W-2:0], 1'b0};
  assign o_both_zero = (i_acc0 == '0) && (i_acc1 == '0);
  assign o_msb_set   = i_acc0[MSG_W-1] | i_acc1[MSG_W-1];

endmodule

// File: rtl/belief_collector.sv
// Variable-node receive side: loads a prior, multiplies in factor messages, renormalises, emits the belief.
// Optional macro BELIEF_ARGMAX_EN adds the registered 'decision' output (acc1 > acc0).
//
// state   | meaning
// IDLE    | waiting for start; prior loaded on start
// COLLECT | msg_ready high, waiting for an incoming message
// MUL     | one-cycle multiply of accumulator by registered message
// NORM    | one left-shift per cycle until an MSB is set or both are zero
// DONE    | belief_valid high, result held until belief_ready
module belief_collector
  import bp_pkg::*;
#(
  parameter int MSG_W   = BP_MSG_W,
  parameter int SHIFT_W = BP_SHIFT_W
) (
  input  logic             CLK100MHZ,
  input  logic             Reset,
  input  logic             start,
  input  logic [MSG_W-1:0] init0,
  input  logic [MSG_W-1:0] init1,
  input  logic             msg_valid,
  output logic             msg_ready,
  input  logic [MSG_W-1:0] msg0,
  input  logic [MSG_W-1:0] msg1,
  input  logic             msg_last,
  output logic             belief_valid,
  input  logic             belief_ready,
  output logic [MSG_W-1:0] belief0,
  output logic [MSG_W-1:0] belief1,
  output logic             zero_belief
`ifdef BELIEF_ARGMAX_EN
  , output logic           decision
`endif
);

  bc_state_t r_state;
  bc_state_t w_state_nxt;

  logic [MSG_W-1:0]   r_acc0;
  logic [MSG_W-1:0]   r_acc1;
  logic [MSG_W-1:0]   r_msg0;
  logic [MSG_W-1:0]   r_msg1;
  logic               r_last_seen;
  logic               r_zero_belief;
  logic [SHIFT_W-1:0] r_shift_cnt;

  logic               w_accept;
  logic [2*MSG_W-1:0] w_prod0;
  logic [2*MSG_W-1:0] w_prod1;
  logic [MSG_W-1:0]   w_mul0;
  logic [MSG_W-1:0]   w_mul1;
  logic [MSG_W-1:0]   w_shl0;
  logic [MSG_W-1:0]   w_shl1;
  logic               w_both_zero;
  logic               w_msb_set;
  logic               w_norm_exit;

  belief_normalizer #(
    .MSG_W (MSG_W)
  ) u_norm (
    .i_acc0      (r_acc0),
    .i_acc1      (r_acc1),
    .o_shl0      (w_shl0),
    .o_shl1      (w_shl1),
    .o_both_zero (w_both_zero),
    .o_msb_set   (w_msb_set)
  );

  // Full-width product, keep the upper half (Q0.W * Q0.W -> Q0.W, truncated)
  assign w_prod0 = {{MSG_W{1'b0}}, r_acc0} * {{MSG_W{1'b0}}, r_msg0};
  assign w_prod1 = {{MSG_W{1'b0}}, r_acc1} * {{MSG_W{1'b0}}, r_msg1};
  assign w_mul0  = MSG_W'(w_prod0 >> MSG_W);
  assign w_mul1  = MSG_W'(w_prod1 >> MSG_W);

  // The count guard bounds NORM even if the detect logic were ever bypassed
  assign w_norm_exit = w_both_zero | w_msb_set |
                       (r_shift_cnt == SHIFT_W'(MSG_W-1));

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_NORM;
      end
      ST_COLLECT: begin
        if (msg_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_MUL;
        end
      end
      ST_MUL: begin
        w_state_nxt = ST_NORM;
      end
      ST_NORM: begin
        if (w_norm_exit) w_state_nxt = r_last_seen ? ST_DONE : ST_COLLECT;
      end
      ST_DONE: begin
        if (belief_ready) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ or posedge Reset) begin
    if (Reset) begin
      r_state       <= ST_IDLE;
      r_acc0        <= '0;
      r_acc1        <= '0;
      r_msg0        <= '0;
      r_msg1        <= '0;
      r_last_seen   <= 1'b0;
      r_zero_belief <= 1'b0;
      r_shift_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_acc0        <= init0;
            r_acc1        <= init1;
            r_zero_belief <= 1'b0;
            r_last_seen   <= 1'b0;
            r_shift_cnt   <= '0;
          end
        end
        ST_COLLECT: begin
          if (w_accept) begin
            r_msg0      <= msg0;
            r_msg1      <= msg1;
            r_last_seen <= msg_last;
          end
        end
        ST_MUL: begin
          r_acc0      <= w_mul0;
          r_acc1      <= w_mul1;
          r_shift_cnt <= '0;
        end
        ST_NORM: begin
          if (w_both_zero) r_zero_belief <= 1'b1;
          if (!w_norm_exit) begin
            r_acc0      <= w_shl0;
            r_acc1      <= w_shl1;
            r_shift_cnt <= r_shift_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef BELIEF_ARGMAX_EN
  logic r_decision;

  // Accumulator does not shift on the exit cycle, so it already holds the final belief
  always_ff @(posedge CLK100MHZ or posedge Reset) begin
    if (Reset) begin
      r_decision <= 1'b0;
    end else if (r_state == ST_NORM && w_norm_exit && r_last_seen) begin
      r_decision <= (r_acc1 > r_acc0);
    end
  end

  assign decision = r_decision;
`endif

  assign msg_ready    = (r_state == ST_COLLECT);
  assign belief_valid = (r_state == ST_DONE);
  assign belief0      = r_acc0;
  assign belief1      = r_acc1;
  assign zero_belief  = r_zero_belief;

endmodule

// File: tb/tb_belief_collector.sv
// Self-checking bench for belief_collector: vector table, scoreboard queue, reference model.
// Build with BELIEF_ARGMAX_EN defined to also check the decision output.
module tb_belief_collector;
  import bp_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] init0, init1;
  logic         msg_valid;
  logic         msg_ready;
  logic [W-1:0] msg0, msg1;
  logic         msg_last;
  logic         belief_valid;
  logic         belief_ready;
  logic [W-1:0] belief0, belief1;
  logic         zero_belief;
`ifdef BELIEF_ARGMAX_EN
  logic         decision;
`endif

  always #5 clk = ~clk;

  belief_collector dut (
    .CLK100MHZ    (clk),
    .Reset        (rst),
    .start        (start),
    .init0        (init0),
    .init1        (init1),
    .msg_valid    (msg_valid),
    .msg_ready    (msg_ready),
    .msg0         (msg0),
    .msg1         (msg1),
    .msg_last     (msg_last),
    .belief_valid (belief_valid),
    .belief_ready (belief_ready),
    .belief0      (belief0),
    .belief1      (belief1),
    .zero_belief  (zero_belief)
`ifdef BELIEF_ARGMAX_EN
    , .decision   (decision)
`endif
  );

  typedef struct {
    logic [W-1:0]      i0, i1;
    int                n;
    logic [2:0][W-1:0] m0, m1;
    int                gap;
    int                bp;
    logic [W-1:0]      e0, e1;
    logic              ez, ed;
    bit                use_model;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] b0, b1;
    logic         z, d;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  int   hs_cnt = 0;
  exp_t sb[$];

  always @(posedge clk) if (msg_valid && msg_ready) hs_cnt <= hs_cnt + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  function automatic void ref_norm(inout logic [W-1:0] a0, inout logic [W-1:0] a1, inout logic z);
    for (int k = 0; k < W; k++) begin
      if (a0 == 0 && a1 == 0) begin
        z = 1'b1;
        break;
      end
      if (a0[W-1] || a1[W-1]) break;
      a0 = a0 << 1;
      a1 = a1 << 1;
    end
  endfunction

  function automatic exp_t model(input vec_t v);
    exp_t         e;
    logic [W-1:0] a0, a1;
    logic         z;
    logic [15:0]  p;
    a0 = v.i0;
    a1 = v.i1;
    z  = 1'b0;
    ref_norm(a0, a1, z);
    for (int k = 0; k < v.n; k++) begin
      p  = 16'(a0) * 16'(v.m0[k]);
      a0 = p[15:8];
      p  = 16'(a1) * 16'(v.m1[k]);
      a1 = p[15:8];
      ref_norm(a0, a1, z);
    end
    e.b0 = a0;
    e.b1 = a1;
    e.z  = z;
    e.d  = (a1 > a0);
    return e;
  endfunction

  function automatic vec_t mk(input logic [W-1:0] i0, i1, input int n,
                              input logic [2:0][W-1:0] m0, m1, input int gap, bp,
                              input logic [W-1:0] e0, e1, input logic ez, ed);
    vec_t v;
    v.i0 = i0; v.i1 = i1; v.n = n; v.m0 = m0; v.m1 = m1;
    v.gap = gap; v.bp = bp; v.e0 = e0; v.e1 = e1; v.ez = ez; v.ed = ed;
    v.use_model = 1'b0;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    int   t;
    int   hs0;
    if (v.use_model) e = model(v);
    else begin
      e.b0 = v.e0; e.b1 = v.e1; e.z = v.ez; e.d = v.ed;
    end
    sb.push_back(e);
    hs0   = hs_cnt;
    init0 = v.i0;
    init1 = v.i1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < v.n; k++) begin
      msg_valid = 1'b1;
      msg0      = v.m0[k];
      msg1      = v.m1[k];
      msg_last  = (k == v.n - 1);
      t = 0;
      while (!msg_ready && t < 60) begin
        step();
        t++;
      end
      if (!msg_ready) begin
        timeout($sformatf("v%0d msg%0d ready", idx, k));
        msg_valid = 1'b0;
        return;
      end
      step();
      msg_valid = 1'b0;
      msg_last  = 1'b0;
      chk($sformatf("v%0d msg%0d ready_low_in_mul", idx, k), msg_ready, 0);
      for (int g = 0; g < v.gap; g++) step();
    end
    t = 0;
    while (!belief_valid && t < 60) begin
      step();
      t++;
    end
    if (!belief_valid) begin
      timeout($sformatf("v%0d belief_valid", idx));
      return;
    end
    e = sb.pop_front();
    chk($sformatf("v%0d handshakes", idx), hs_cnt - hs0, v.n);
    chk($sformatf("v%0d belief0", idx), belief0, e.b0);
    chk($sformatf("v%0d belief1", idx), belief1, e.b1);
    chk($sformatf("v%0d zero_belief", idx), zero_belief, e.z);
`ifdef BELIEF_ARGMAX_EN
    chk($sformatf("v%0d decision", idx), decision, e.d);
`endif
    for (int b = 0; b < v.bp; b++) begin
      start     = 1'b1;
      msg_valid = 1'b1;
      step();
      chk($sformatf("v%0d bp%0d valid", idx, b), belief_valid, 1);
      chk($sformatf("v%0d bp%0d belief", idx, b), {belief0, belief1}, {e.b0, e.b1});
      chk($sformatf("v%0d bp%0d msg_ready", idx, b), msg_ready, 0);
    end
    start     = 1'b0;
    msg_valid = 1'b0;
    belief_ready = 1'b1;
    step();
    belief_ready = 1'b0;
    chk($sformatf("v%0d released_valid", idx), belief_valid, 0);
    chk($sformatf("v%0d idle_msg_ready", idx), msg_ready, 0);
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = mk(BP_UNIFORM_BELIEF, BP_UNIFORM_BELIEF, 1, {8'h00, 8'h00, 8'h80}, {8'h00, 8'h00, 8'h40},
                0, 0, 8'h80, 8'h40, 1'b0, 1'b0);
    tbl[1] = mk(8'h01, 8'h00, 1, {8'h00, 8'h00, 8'hFF}, {8'h00, 8'h00, 8'hFF},
                0, 0, 8'hFE, 8'h00, 1'b0, 1'b0);
    tbl[2] = mk(8'h80, 8'h80, 2, {8'h00, 8'h80, 8'h00}, {8'h00, 8'h80, 8'h00},
                1, 0, 8'h00, 8'h00, 1'b1, 1'b0);
    tbl[3] = mk(8'h80, 8'h80, 1, {8'h00, 8'h00, 8'h40}, {8'h00, 8'h00, 8'hC0},
                0, 5, 8'h40, 8'hC0, 1'b0, 1'b1);
    tbl[4] = mk(8'h80, 8'h80, 3, {8'h80, 8'hC0, 8'h80}, {8'h80, 8'h80, 8'hC0},
                2, 0, 8'hC0, 8'hC0, 1'b0, 1'b0);
    for (int r = 5; r < 7; r++) begin
      tbl[r] = mk(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), $urandom_range(1, 3),
                  {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))},
                  {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))},
                  1, 1, 8'h00, 8'h00, 1'b0, 1'b0);
      tbl[r].use_model = 1'b1;
    end

    rst = 1'b1;
    start = 1'b0; init0 = '0; init1 = '0;
    msg_valid = 1'b0; msg0 = '0; msg1 = '0; msg_last = 1'b0;
    belief_ready = 1'b0;
    step();
    step();
    chk("rst belief_valid", belief_valid, 0);
    chk("rst msg_ready", msg_ready, 0);
    chk("rst zero_belief", zero_belief, 0);
    chk("rst belief", {belief0, belief1}, 16'h0000);
`ifdef BELIEF_ARGMAX_EN
    chk("rst decision", decision, 0);
`endif
    rst = 1'b0;
    step();

    // abort a belief while it is still shifting the 01/01 prior
    init0 = 8'h01;
    init1 = 8'h01;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("midnorm shifting", {belief0, belief1}, 16'h0404);
    rst = 1'b1;
    #1;
    chk("midnorm rst belief", {belief0, belief1}, 16'h0000);
    chk("midnorm rst valid", belief_valid, 0);
    chk("midnorm rst msg_ready", msg_ready, 0);
    chk("midnorm rst zero", zero_belief, 0);
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

    chk("scoreboard empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
